// File: rtl/polar_butterfly_encoder_if.sv
// polar_butterfly_encoder_if: frame-in / codeword-out valid-ready handshakes
interface polar_butterfly_encoder_if #(
  parameter int N = 256,
  parameter int K = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/polar_butterfly_encoder.sv
// polar_butterfly_encoder: iterative polar encoder, one butterfly stage per clock; POLAR_BITREV_OUT_EN selects bit-reversed output order
module polar_butterfly_encoder #(
  parameter int             N         = 256,
  parameter int             K         = 128,
  parameter int             LOG2N     = 8,
  parameter logic [N-1:0]   INFO_MASK = {{128{1'b1}}, {128{1'b0}}}
) (
  input  logic                       clk,
  input  logic                       reset,
  polar_butterfly_encoder_if.slave   bus,
  output logic                       busy,
  output logic [15:0]                frame_cnt
);
  localparam int SW = $clog2(LOG2N) + 1;
  localparam logic [SW-1:0] LAST = SW'(LOG2N - 1);
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t         state;
  logic [N-1:0]   u;
  logic [N-1:0]   u_map;
  logic [N-1:0]   u_nxt;
  logic [SW-1:0]  stage;
  logic [N-1:0]   stg [LOG2N];
  function automatic int rank(int i);
    int r = 0;
    for (int b = 0; b < i; b++) r += int'(INFO_MASK[b]);
    return r;
  endfunction
  for (genvar i = 0; i < N; i++) begin : g_map
    if (INFO_MASK[i]) begin : g_info
      assign u_map[i] = bus.in_data[rank(i)];
    end else begin : g_frozen
      assign u_map[i] = 1'b0;
    end
  end
  for (genvar s = 0; s < LOG2N; s++) begin : g_stg
    for (genvar i = 0; i < N; i++) begin : g_bit
      if ((i >> s) % 2 == 1) begin : g_hi
        assign stg[s][i] = u[i];
      end else begin : g_lo
        assign stg[s][i] = u[i] ^ u[i + (1 << s)];
      end
    end
  end
  // pick the butterfly stage selected by the stage counter
  always_comb begin
    u_nxt = u;
    for (int s = 0; s < LOG2N; s++) u_nxt = (stage == s[SW-1:0]) ? stg[s] : u_nxt;
  end
`ifdef POLAR_BITREV_OUT_EN
  function automatic int rev(int j);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r[LOG2N-1-b] = j[b];
    return r;
  endfunction
  for (genvar j = 0; j < N; j++) begin : g_rev
    assign bus.out_data[rev(j)] = u[j];
  end
`else
  assign bus.out_data = u;
`endif
  // frame FSM: accept, run LOG2N stages, hold codeword until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      u             <= '0;
      stage         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          u            <= u_map;
          stage        <= '0;
          state        <= ENC;
          bus.in_ready <= 1'b0;
          busy         <= 1'b1;
        end
        ENC: begin
          u     <= u_nxt;
          stage <= stage + 1'b1;
          if (stage == LAST) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          frame_cnt     <= frame_cnt + 16'd1;
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_polar_butterfly_encoder.sv
// tb_polar_butterfly_encoder: directed checks of the N=8, K=4 polar encoder
module tb_polar_butterfly_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] exp_cnt = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  got [$];
  time         acc [5];
`ifdef POLAR_BITREV_OUT_EN
  localparam logic [7:0] E1 = 8'h55, E2 = 8'h33, E4 = 8'h0F, E8 = 8'hFF, E3 = 8'h66;
`else
  localparam logic [7:0] E1 = 8'h0F, E2 = 8'h33, E4 = 8'h55, E8 = 8'hFF, E3 = 8'h3C;
`endif
  logic [3:0] bw [5];
  logic [7:0] be [5];
  polar_butterfly_encoder_if #(.N(8), .K(4)) bus ();
  polar_butterfly_encoder #(.N(8), .K(4), .LOG2N(3), .INFO_MASK(8'b1110_1000)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .busy(busy),
    .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mon_en && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] d, input logic [7:0] exp, input string tag, input int hold);
    int n;
    check({tag, "_rdy"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = (h == 2);
      bus.in_data = ~d;
      @(posedge clk); #1;
      check({tag, "_hold_data"}, 32'(bus.out_data), 32'(exp));
      check({tag, "_hold_rdy"}, 32'(bus.in_ready), 0);
      check({tag, "_hold_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check({tag, "_idle"}, 32'(bus.in_ready), 1);
    check({tag, "_vld_lo"}, 32'(bus.out_valid), 0);
    if (hold > 0) begin
      repeat (5) @(posedge clk);
      #1;
      check({tag, "_no_ghost"}, 32'({bus.out_valid, busy}), 0);
    end
  endtask
  initial begin
    int n;
    bw = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
    be = '{E1, E2, E4, E8, E3};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(bus.out_valid), 0);
    check("rst_rdy", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_data", 32'(bus.out_data), 0);
    reset = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 4'b1000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_vld", 32'(bus.out_valid), 0);
    check("mid_rdy", 32'(bus.in_ready), 1);
    check("mid_busy_clr", 32'(busy), 0);
    check("mid_cnt", 32'(frame_cnt), 0);
    check("mid_data", 32'(bus.out_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_no_out", 32'(bus.out_valid), 0);
    send(4'b0001, E1, "w1", 0);
    send(4'b0010, E2, "w2", 0);
    send(4'b1000, E8, "w8", 0);
    send(4'b0011, E3, "w3", 0);
    send(4'b0000, 8'h00, "w0", 0);
    send(4'b0001, E1, "bp", 10);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = bw[k];
      n = 0;
      while (!bus.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      acc[k] = $time;
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    bus.out_ready = 1'b0;
    mon_en = 1'b0;
    check("b2b_count", got.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("b2b_data%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hDEAD, 32'(be[k]));
    for (int k = 1; k < 5; k++) check($sformatf("b2b_gap%0d", k), int'(acc[k] - acc[k-1]), 50);
    exp_cnt = exp_cnt + 16'd5;
    check("b2b_cnt", 32'(frame_cnt), 32'(exp_cnt));
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    send(4'b1000, E8, "wrap", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/polar_butterfly_encoder.md
Name: polar_butterfly_encoder

Overview:
- Downstream consumer of the serial-to-parallel collector.
- Takes one K-bit parallel information word per frame over a valid/ready handshake.
- Places the information bits into the non-frozen positions of an N-bit vector u; frozen positions are 0.
- Computes the polar codeword x = u·F^{⊗n}, F = [[1,0],[1,1]], iteratively: one butterfly stage per clock, then holds the N-bit codeword until it is taken.

Parameters:
- N, 256, codeword length; power of two, ≥ 2.
- K, 128, information bits per frame; 1 ≤ K ≤ N.
- LOG2N, 8, log2(N); must match N.
- INFO_MASK, {128{1'b1},128{1'b0}}, N-bit mask; bit i = 1 marks u[i] as an information position. Popcount must equal K.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a frame.
- in_data  input  K  information bits, in_data[0] first.
- out_valid  output  1  out_data holds a complete codeword.
- out_ready  input  1  downstream accepts the codeword.
- out_data  output  N  codeword, x[0] at bit 0.
- busy  output  1  a frame is in flight (ENC or DONE).
- frame_cnt  output  16  completed frames handed off.

Behaviour:
- Reset (async, any state):
  - state = IDLE; u register = 0; stage counter = 0.
  - out_data = 0, out_valid = 0, busy = 0, frame_cnt = 0.
  - A frame in progress is discarded; no partial output.
- Bit mapping: in_data[j] goes to u[p_j], where p_j is the j-th set bit of INFO_MASK in ascending index order. All other u bits are 0. Mapping is combinational on in_data and registered at accept.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready at an edge: load mapped u, stage = 0, go to ENC.
  - ENC: in_ready = 0, busy = 1. Each edge applies stage s = stage counter: for every i with bit s of i equal to 0, u[i] <= u[i] ^ u[i + 2^s]; u[i + 2^s] is unchanged. Stage counter increments. The edge that applies s = LOG2N-1 moves to DONE.
  - DONE: out_valid = 1, busy = 1, out_data = u. Hold until out_ready = 1 at an edge; that edge increments frame_cnt and moves to IDLE.
- Latency: out_valid first seen high after exactly LOG2N rising edges following the accept edge (N=8: 3 edges).
- Throughput: one frame per LOG2N + 2 cycles minimum.
- in_valid is ignored outside IDLE; in_data need not be held after the accept edge.
- out_data is stable throughout DONE.
- out_ready while out_valid = 0 has no effect.
- frame_cnt wraps 16'hFFFF → 0.
- Stage counter width is clog2(LOG2N) + 1; it never exceeds LOG2N-1 while in ENC.

Optional Feature:
- Macro: POLAR_BITREV_OUT_EN.
- Defined: out_data[rev(j)] = x[j], where rev reverses the LOG2N-bit index (bit-reversed codeword order, per the standard G = B_N·F^{⊗n}). Internal arithmetic, latency and handshake are unchanged.
- Undefined: natural order, out_data[j] = x[j].

Test Plan (instance N=8, K=4, LOG2N=3, INFO_MASK=8'b1110_1000, so info positions 3, 5, 6, 7):
- Reset mid-ENC (assert 1 cycle after accept) -> out_valid = 0, in_ready = 1, frame_cnt = 0, out_data = 8'h00 immediately, without waiting for a clock edge.
- in_data = 4'b0001 -> u[3] = 1 -> out_data = 8'h0F; out_valid rises 3 edges after accept. With POLAR_BITREV_OUT_EN defined: out_data = 8'h55.
- in_data = 4'b0010 -> 8'h33 (same with POLAR_BITREV_OUT_EN). in_data = 4'b1000 -> 8'hFF. in_data = 4'b0011 -> 8'h3C. in_data = 4'b0000 -> 8'h00.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_data constant, in_ready = 0, a second in_valid pulse is ignored, frame_cnt unchanged. Raise out_ready -> frame_cnt +1, IDLE on the next cycle.
- Back-to-back: in_valid held high with 5 different words and out_ready = 1 -> 5 codewords in order, each in_ready/accept exactly LOG2N + 2 cycles apart, frame_cnt = 5.
- Wrap: force frame_cnt to 16'hFFFF, complete one frame -> frame_cnt = 16'h0000.
